// File: rtl/ranging_sequencer.sv
`default_nettype none
// ============================================================================
// ranging_sequencer - ultrasonic ranger trigger, echo timing and publish FSM
// Optional: RANGING_AVG4_EN publishes a 4-result moving average.  Rev 1.0
// ============================================================================
module ranging_sequencer #(
  parameter int CNT_W          = 12,
  parameter int TRIG_CYCLES    = 1000,
  parameter int TICK_DIV       = 588,
  parameter int ECHO_TO_CYCLES = 2000000,
  parameter int GAP_CYCLES     = 6000000
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_en,
  input  logic             echo,
  output logic             stimulus,
  output logic [CNT_W-1:0] distance,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int c_MAX_A  = (TRIG_CYCLES > ECHO_TO_CYCLES) ? TRIG_CYCLES : ECHO_TO_CYCLES;
  localparam int c_MAX_B  = (c_MAX_A > GAP_CYCLES) ? c_MAX_A : GAP_CYCLES;
  localparam int c_TMR_W  = $clog2(c_MAX_B + 1);
  localparam int c_PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TMR_W-1:0] c_TRIG_LAST = c_TMR_W'(TRIG_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_ECHO_LAST = c_TMR_W'(ECHO_TO_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LAST  = c_TMR_W'(GAP_CYCLES - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } t_state;

  t_state             r_state, w_next;
  logic [c_TMR_W-1:0] r_timer;
  logic [c_PRE_W-1:0] r_pre;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_echo_s1, r_echo_s2, r_echo_d;
  logic               w_rise, w_fall, w_wrap, w_sat;
  logic               w_pub_meas, w_pub_to;
  logic               r_stimulus, r_valid, r_timeout, r_busy;
  logic [CNT_W-1:0]   r_distance;

  assign w_rise     = r_echo_s2 & ~r_echo_d;
  assign w_fall     = ~r_echo_s2 & r_echo_d;
  assign w_wrap     = (r_pre == c_PRE_LAST);
  assign w_sat      = w_wrap && (r_cnt == {CNT_W{1'b1}});
  // Count including this cycle's tick; held at all-ones on saturation.
  assign w_cnt_next = w_sat ? r_cnt : r_cnt + CNT_W'(w_wrap);

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_stimulus <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE);
      r_stimulus <= (w_next == S_TRIG);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pub_meas = 1'b0;
    w_pub_to   = 1'b0;
    case (r_state)
      S_IDLE:      if (start || auto_en) w_next = S_TRIG;
      S_TRIG:      if (r_timer == c_TRIG_LAST) w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_next = S_MEASURE;
        end else if (r_timer == c_ECHO_LAST) begin
          w_pub_to = 1'b1;
          w_next   = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        if (w_fall) begin
          w_pub_meas = 1'b1;
          w_next     = S_HOLDOFF;
        end else if (w_sat) begin
          w_pub_to = 1'b1;
          w_next   = S_HOLDOFF;
        end
      end
      S_HOLDOFF:   if (r_timer == c_GAP_LAST) w_next = auto_en ? S_TRIG : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
      r_timer   <= '0;
      r_pre     <= '0;
      r_cnt     <= '0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (r_state != S_IDLE) begin
        r_timer <= r_timer + c_TMR_W'(1);
      end
      if (r_state != S_MEASURE) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else begin
        r_pre <= w_wrap ? '0 : r_pre + c_PRE_W'(1);
        r_cnt <= w_cnt_next;
      end
    end
  end

`ifdef RANGING_AVG4_EN
  logic               r_pend, r_primed;
  logic [CNT_W-1:0]   r_raw, r_hist0, r_hist1, r_hist2;
  logic [CNT_W+1:0]   w_sum;

  assign w_sum = {2'b00, r_raw} + {2'b00, r_hist0} + {2'b00, r_hist1} + {2'b00, r_hist2};

  // Measured results are averaged one cycle later; timeouts bypass the history.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= 1'b0;
      r_primed   <= 1'b0;
      r_raw      <= '0;
      r_hist0    <= '0;
      r_hist1    <= '0;
      r_hist2    <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_distance <= '0;
    end else begin
      r_pend  <= w_pub_meas;
      r_raw   <= w_cnt_next;
      r_valid <= w_pub_to | r_pend;
      if (w_pub_to) begin
        r_distance <= {CNT_W{1'b1}};
        r_timeout  <= 1'b1;
      end else if (r_pend) begin
        r_timeout <= 1'b0;
        r_primed  <= 1'b1;
        if (!r_primed) begin
          r_hist0    <= r_raw;
          r_hist1    <= r_raw;
          r_hist2    <= r_raw;
          r_distance <= r_raw;
        end else begin
          r_hist0    <= r_raw;
          r_hist1    <= r_hist0;
          r_hist2    <= r_hist1;
          r_distance <= w_sum[CNT_W+1:2];
        end
      end
    end
  end
`else
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_distance <= '0;
    end else begin
      r_valid <= w_pub_meas | w_pub_to;
      if (w_pub_to) begin
        r_distance <= {CNT_W{1'b1}};
        r_timeout  <= 1'b1;
      end else if (w_pub_meas) begin
        r_distance <= w_cnt_next;
        r_timeout  <= 1'b0;
      end
    end
  end
`endif

  assign stimulus = r_stimulus;
  assign distance = r_distance;
  assign valid    = r_valid;
  assign timeout  = r_timeout;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ranging_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ranging_sequencer - directed vector bench for ranging_sequencer
// Rev 1.0
// ============================================================================
module tb_ranging_sequencer;

`ifdef RANGING_AVG4_EN
  localparam int c_AVG = 1;
`else
  localparam int c_AVG = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, auto_en, echo;
  logic       stimulus, valid, timeout, busy;
  logic [7:0] distance;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ranging_sequencer #(
    .CNT_W(8), .TRIG_CYCLES(10), .TICK_DIV(4), .ECHO_TO_CYCLES(100), .GAP_CYCLES(20)
  ) dut (
    .system_clk(clk), .reset(reset), .start(start), .auto_en(auto_en), .echo(echo),
    .stimulus(stimulus), .distance(distance), .valid(valid), .timeout(timeout), .busy(busy)
  );

  typedef struct {
    int dly;
    int wid;
    int exp_d;
    bit exp_t;
    int exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Runs one measurement: trigger, echo schedule relative to stimulus fall, publish.
  task automatic meas(input bit pulse, input int dly, input int wid, input bit clr_auto,
                      input int exp_d, input bit exp_t, input int exp_lat,
                      input int exp_gap, input bit tail, input string nm);
    int n;
    int lat;
    int lag;
    int vcnt;
    bit seen;
    lag = exp_t ? 0 : c_AVG;
    if (pulse) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    n = 0;
    while (!stimulus && n < 200) begin
      step();
      n++;
    end
    if (!stimulus) begin
      chk({nm, "/stim_rise_wait"}, 0, 1);
      return;
    end
    if (exp_gap >= 0) chk({nm, "/gap"}, n + 1, exp_gap);
    n = 0;
    while (stimulus && n < 100) begin
      step();
      n++;
    end
    chk({nm, "/stim_len"}, n, 10);
    if (clr_auto) auto_en = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      echo = (k >= dly) && (k < dly + wid);
      step();
      if (valid) begin
        seen = 1'b1;
        lat  = k + 1;
      end
    end
    if (!seen) begin
      echo = 1'b0;
      chk({nm, "/valid_wait"}, 0, 1);
      return;
    end
    chk({nm, "/distance"}, int'(distance), exp_d);
    chk({nm, "/timeout"}, int'(timeout), int'(exp_t));
    chk({nm, "/latency"}, lat, exp_lat + lag);
    echo = 1'b0;
    step();
    chk({nm, "/valid_width"}, int'(valid), 0);
    if (tail) begin
      vcnt = 0;
      repeat (18 - lag) begin
        step();
        if (valid) vcnt++;
      end
      chk({nm, "/busy_holdoff"}, int'(busy), 1);
      step();
      chk({nm, "/busy_idle"}, int'(busy), 0);
      chk({nm, "/extra_valid"}, vcnt, 0);
    end
  endtask

  initial begin
    int cnt;
    tbl[0] = '{dly: 5,  wid: 40,   exp_d: 10,  exp_t: 1'b0, exp_lat: 48};
    tbl[1] = '{dly: 5,  wid: 80,   exp_d: 20,  exp_t: 1'b0, exp_lat: 88};
    tbl[2] = '{dly: 2,  wid: 3,    exp_d: 0,   exp_t: 1'b0, exp_lat: 8};
    tbl[3] = '{dly: 0,  wid: 7,    exp_d: 1,   exp_t: 1'b0, exp_lat: 10};
    tbl[4] = '{dly: 5,  wid: 0,    exp_d: 255, exp_t: 1'b1, exp_lat: 100};
    tbl[5] = '{dly: 5,  wid: 1100, exp_d: 255, exp_t: 1'b1, exp_lat: 1032};
    tbl[6] = '{dly: 97, wid: 8,    exp_d: 2,   exp_t: 1'b0, exp_lat: 108};
    tbl[7] = '{dly: 98, wid: 8,    exp_d: 255, exp_t: 1'b1, exp_lat: 100};

    reset = 1'b0; start = 1'b0; auto_en = 1'b0; echo = 1'b0;
    repeat (3) step();
    chk("rst/stimulus", int'(stimulus), 0);
    chk("rst/distance", int'(distance), 0);
    chk("rst/valid", int'(valid), 0);
    chk("rst/timeout", int'(timeout), 0);
    chk("rst/busy", int'(busy), 0);
    reset = 1'b1;
    step();

`ifndef RANGING_AVG4_EN
    for (int i = 0; i < 8; i++) begin
      meas(1'b1, tbl[i].dly, tbl[i].wid, 1'b0, tbl[i].exp_d, tbl[i].exp_t,
           tbl[i].exp_lat, -1, 1'b1, $sformatf("vec%0d", i));
      step();
    end

    auto_en = 1'b1;
    meas(1'b0, 5, 40,  1'b0, 10, 1'b0, 48,  -1, 1'b0, "auto0");
    meas(1'b0, 5, 80,  1'b0, 20, 1'b0, 88,  20, 1'b0, "auto1");
    meas(1'b0, 5, 120, 1'b1, 30, 1'b0, 128, 20, 1'b1, "auto2");
    cnt = 0;
    repeat (30) begin
      step();
      if (stimulus || busy) cnt++;
    end
    chk("auto/stays_idle", cnt, 0);
`endif

    // Reset during MEASURE: outputs clear with no clock edge.
    start = 1'b1; step(); start = 1'b0;
    cnt = 0;
    while (!stimulus && cnt < 50) begin step(); cnt++; end
    while (stimulus && cnt < 100) begin step(); cnt++; end
    echo = 1'b1;
    repeat (10) step();
    chk("rstm/busy_before", int'(busy), 1);
    #3 reset = 1'b0;
    #1;
    chk("rstm/busy", int'(busy), 0);
    chk("rstm/distance", int'(distance), 0);
    chk("rstm/valid", int'(valid), 0);
    echo = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Reset during TRIG: stimulus drops asynchronously.
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("rstt/stim_before", int'(stimulus), 1);
    #3 reset = 1'b0;
    #1;
    chk("rstt/stimulus", int'(stimulus), 0);
    chk("rstt/busy", int'(busy), 0);
    step();
    reset = 1'b1;
    step();
    meas(1'b1, 5, 40, 1'b0, 10, 1'b0, 48, -1, 1'b1, "post_rst");
    step();

`ifdef RANGING_AVG4_EN
    meas(1'b1, 5, 40,  1'b0, 10,  1'b0, 48,  -1, 1'b1, "avg1"); step();
    meas(1'b1, 5, 40,  1'b0, 10,  1'b0, 48,  -1, 1'b1, "avg2"); step();
    meas(1'b1, 5, 0,   1'b0, 255, 1'b1, 100, -1, 1'b1, "avg_to"); step();
    meas(1'b1, 5, 120, 1'b0, 15,  1'b0, 128, -1, 1'b1, "avg3"); step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
